// File: rtl/irq_sched.sv
// Fixed-priority machine interrupt scheduler (MEI > MSI > MTI) with an IDLE/REQ/SERVICE handshake.
// Define IRQ_SCHED_TIMER_EN to build the internal 64-bit mtime/mtimecmp timer; otherwise mtip_i is used.
module irq_sched #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMER_DIV   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        meip_i,
  input  logic        msip_i,
  input  logic        mtip_i,
  input  logic [31:0] mie_i,
  input  logic        global_int_en_i,
  input  logic        busy_i,
  output logic        irq_req_o,
  output logic [31:0] irq_cause_o,
  input  logic        irq_ack_i,
  input  logic        mret_i,
  input  logic        tmr_we_i,
  input  logic [1:0]  tmr_sel_i,
  input  logic [31:0] tmr_wdata_i,
  output logic [63:0] mtime_o,
  output logic [63:0] mtimecmp_o
);

  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        load_cause;
  logic [SYNC_STAGES-1:0] meip_sync_q;
  logic        meip_s;
  logic        mtip;
  logic        any_elig;
  logic [31:0] win_cause;

  // meip_i is asynchronous; only the last synchronizer stage is trusted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meip_sync_q <= '0;
    end else begin
      meip_sync_q <= {meip_sync_q[SYNC_STAGES-2:0], meip_i};
    end
  end

  assign meip_s = meip_sync_q[SYNC_STAGES-1];

`ifdef IRQ_SCHED_TIMER_EN
  logic [63:0] mtime_q;
  logic [63:0] mtimecmp_q;
  logic [7:0]  div_cnt_q;
  logic        div_tick;
  logic        unused_timer;

  assign div_tick = (div_cnt_q == 8'(TIMER_DIV - 1));

  // A write to either mtime half takes precedence over the increment and restarts the divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      div_cnt_q  <= '0;
    end else begin
      if (tmr_we_i && (tmr_sel_i == 2'd0)) begin
        mtime_q[31:0] <= tmr_wdata_i;
        div_cnt_q     <= '0;
      end else if (tmr_we_i && (tmr_sel_i == 2'd1)) begin
        mtime_q[63:32] <= tmr_wdata_i;
        div_cnt_q      <= '0;
      end else if (div_tick) begin
        mtime_q   <= mtime_q + 64'd1;
        div_cnt_q <= '0;
      end else begin
        div_cnt_q <= div_cnt_q + 8'd1;
      end
      if (tmr_we_i && (tmr_sel_i == 2'd2)) begin
        mtimecmp_q[31:0] <= tmr_wdata_i;
      end
      if (tmr_we_i && (tmr_sel_i == 2'd3)) begin
        mtimecmp_q[63:32] <= tmr_wdata_i;
      end
    end
  end

  assign mtip         = (mtime_q >= mtimecmp_q);
  assign mtime_o      = mtime_q;
  assign mtimecmp_o   = mtimecmp_q;
  assign unused_timer = mtip_i;
`else
  logic unused_timer;

  assign mtip         = mtip_i;
  assign mtime_o      = '0;
  assign mtimecmp_o   = '0;
  assign unused_timer = ^{tmr_we_i, tmr_sel_i, tmr_wdata_i};
`endif

  logic unused_mie;
  assign unused_mie = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};

  always_comb begin
    any_elig  = 1'b1;
    win_cause = CAUSE_MEI;
    if (global_int_en_i && meip_s && mie_i[11]) begin
      win_cause = CAUSE_MEI;
    end else if (global_int_en_i && msip_i && mie_i[3]) begin
      win_cause = CAUSE_MSI;
    end else if (global_int_en_i && mtip && mie_i[7]) begin
      win_cause = CAUSE_MTI;
    end else begin
      any_elig = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Ack only matters in REQ and mret only in SERVICE; everything else holds
  always_comb begin
    state_d    = state_q;
    load_cause = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_elig && !busy_i) begin
          state_d    = REQ;
          load_cause = 1'b1;
        end
      end
      REQ: begin
        if (irq_ack_i) begin
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (mret_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_cause_o <= '0;
    end else if (load_cause) begin
      irq_cause_o <= win_cause;
    end
  end

  assign irq_req_o = (state_q == REQ);

endmodule

// File: tb/tb_irq_sched.sv
// Directed self-checking bench for irq_sched; a reference model is compared every cycle.
// Timer checks are active when IRQ_SCHED_TIMER_EN is defined.
module tb_irq_sched;

  localparam int SYNC = 2;
  localparam int DIV  = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        meip_i = 1'b0;
  logic        msip_i = 1'b0;
  logic        mtip_i = 1'b0;
  logic [31:0] mie_i = '0;
  logic        global_int_en_i = 1'b0;
  logic        busy_i = 1'b0;
  logic        irq_req_o;
  logic [31:0] irq_cause_o;
  logic        irq_ack_i = 1'b0;
  logic        mret_i = 1'b0;
  logic        tmr_we_i = 1'b0;
  logic [1:0]  tmr_sel_i = '0;
  logic [31:0] tmr_wdata_i = '0;
  logic [63:0] mtime_o;
  logic [63:0] mtimecmp_o;

  int checks = 0;
  int errors = 0;

  irq_sched #(.SYNC_STAGES(SYNC), .TIMER_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .meip_i(meip_i), .msip_i(msip_i), .mtip_i(mtip_i),
    .mie_i(mie_i), .global_int_en_i(global_int_en_i), .busy_i(busy_i),
    .irq_req_o(irq_req_o), .irq_cause_o(irq_cause_o), .irq_ack_i(irq_ack_i),
    .mret_i(mret_i), .tmr_we_i(tmr_we_i), .tmr_sel_i(tmr_sel_i),
    .tmr_wdata_i(tmr_wdata_i), .mtime_o(mtime_o), .mtimecmp_o(mtimecmp_o)
  );

  always #5 clk = ~clk;

  // Reference model: an outstanding request and an in-service flag, plus a timer
  // expressed as a base value advanced by elapsed cycles.
  bit          mdl_pending = 1'b0;
  bit          mdl_service = 1'b0;
  logic [31:0] mdl_cause = '0;
  bit          mdl_meip_hist [SYNC];
  logic [63:0] mdl_base = '0;
  longint      mdl_cycles = 0;
  logic [63:0] mdl_cmp = '1;
  logic [63:0] mdl_mtime;
  bit          mdl_mti;

  assign mdl_mtime = mdl_base + 64'(mdl_cycles / DIV);
`ifdef IRQ_SCHED_TIMER_EN
  assign mdl_mti = (mdl_mtime >= mdl_cmp);
`else
  assign mdl_mti = mtip_i;
`endif

  function automatic logic [32:0] pick(bit mei, bit msi, bit mti, logic [31:0] mie, bit gie);
    if (gie && mei && mie[11]) return {1'b1, 32'h8000_000B};
    if (gie && msi && mie[3])  return {1'b1, 32'h8000_0003};
    if (gie && mti && mie[7])  return {1'b1, 32'h8000_0007};
    return {1'b0, 32'h0};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_pending <= 1'b0;
      mdl_service <= 1'b0;
      mdl_cause   <= '0;
      for (int i = 0; i < SYNC; i++) mdl_meip_hist[i] <= 1'b0;
      mdl_base    <= '0;
      mdl_cycles  <= 0;
      mdl_cmp     <= '1;
    end else begin
      mdl_meip_hist[0] <= meip_i;
      for (int i = 1; i < SYNC; i++) mdl_meip_hist[i] <= mdl_meip_hist[i-1];
      if (!mdl_pending && !mdl_service) begin
        if (pick(mdl_meip_hist[SYNC-1], msip_i, mdl_mti, mie_i, global_int_en_i) >> 32 != 0
            && !busy_i) begin
          mdl_pending <= 1'b1;
          mdl_cause   <= pick(mdl_meip_hist[SYNC-1], msip_i, mdl_mti, mie_i, global_int_en_i) & 33'hFFFF_FFFF;
        end
      end else if (mdl_pending) begin
        if (irq_ack_i) begin
          mdl_pending <= 1'b0;
          mdl_service <= 1'b1;
        end
      end else if (mret_i) begin
        mdl_service <= 1'b0;
      end
`ifdef IRQ_SCHED_TIMER_EN
      if (tmr_we_i && tmr_sel_i == 2'd0) begin
        mdl_base   <= {mdl_mtime[63:32], tmr_wdata_i};
        mdl_cycles <= 0;
      end else if (tmr_we_i && tmr_sel_i == 2'd1) begin
        mdl_base   <= {tmr_wdata_i, mdl_mtime[31:0]};
        mdl_cycles <= 0;
      end else begin
        mdl_cycles <= mdl_cycles + 1;
      end
      if (tmr_we_i && tmr_sel_i == 2'd2) mdl_cmp <= {mdl_cmp[63:32], tmr_wdata_i};
      if (tmr_we_i && tmr_sel_i == 2'd3) mdl_cmp <= {tmr_wdata_i, mdl_cmp[31:0]};
`endif
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("cyc_req", 64'(irq_req_o), 64'(mdl_pending));
      checkOutput("cyc_cause", 64'(irq_cause_o), 64'(mdl_cause));
`ifdef IRQ_SCHED_TIMER_EN
      checkOutput("cyc_mtime", mtime_o, mdl_mtime);
      checkOutput("cyc_mtimecmp", mtimecmp_o, mdl_cmp);
`else
      checkOutput("cyc_mtime", mtime_o, 64'd0);
      checkOutput("cyc_mtimecmp", mtimecmp_o, 64'd0);
`endif
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit meip, input bit msip, input bit mtip,
                               input logic [31:0] mie, input bit gie, input bit busy);
    meip_i = meip;
    msip_i = msip;
    mtip_i = mtip;
    mie_i = mie;
    global_int_en_i = gie;
    busy_i = busy;
  endtask

  task automatic pulseAck();
    irq_ack_i = 1'b1;
    waitCycles(1);
    irq_ack_i = 1'b0;
  endtask

  task automatic pulseMret();
    mret_i = 1'b1;
    waitCycles(1);
    mret_i = 1'b0;
  endtask

  task automatic tmrWrite(input logic [1:0] sel, input logic [31:0] data);
    tmr_we_i = 1'b1;
    tmr_sel_i = sel;
    tmr_wdata_i = data;
    waitCycles(1);
    tmr_we_i = 1'b0;
  endtask

  initial begin
    #12;
    $display("[TB] reset state");
    checkOutput("rst_req", 64'(irq_req_o), 64'd0);
    checkOutput("rst_cause", 64'(irq_cause_o), 64'd0);
    checkOutput("rst_mtime", mtime_o, 64'd0);
`ifdef IRQ_SCHED_TIMER_EN
    checkOutput("rst_mtimecmp", mtimecmp_o, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    checkOutput("rst_mtimecmp", mtimecmp_o, 64'd0);
`endif
    #10 rst_n = 1'b1;
    waitCycles(1);

    $display("[TB] priority MEI over MSI over MTI");
    applyStimulus(1, 1, 1, 32'h888, 1, 1);
    waitCycles(4);
    checkOutput("busy_hold_req", 64'(irq_req_o), 64'd0);
    busy_i = 1'b0;
    waitCycles(1);
    checkOutput("prio_req", 64'(irq_req_o), 64'd1);
    checkOutput("prio_cause_mei", 64'(irq_cause_o), 64'h8000_000B);
    pulseAck();
    waitCycles(1);
    checkOutput("ack_drops_req", 64'(irq_req_o), 64'd0);
    meip_i = 1'b0;
    waitCycles(4);
    checkOutput("service_no_req", 64'(irq_req_o), 64'd0);
    pulseMret();
    waitCycles(1);
    checkOutput("next_cause_msi", 64'(irq_cause_o), 64'h8000_0003);

    $display("[TB] request held after source drops");
    msip_i = 1'b0;
    mtip_i = 1'b0;
    waitCycles(10);
    checkOutput("held_req", 64'(irq_req_o), 64'd1);
    checkOutput("held_cause", 64'(irq_cause_o), 64'h8000_0003);
    pulseAck();
    pulseMret();
    waitCycles(2);

    $display("[TB] ack ignored while idle");
    pulseAck();
    msip_i = 1'b1;
    waitCycles(1);
    checkOutput("idle_ack_ignored", 64'(irq_req_o), 64'd1);
    pulseAck();
    msip_i = 1'b0;
    pulseMret();
    waitCycles(2);

    $display("[TB] busy blocks selection");
    applyStimulus(0, 1, 0, 32'h008, 1, 1);
    waitCycles(5);
    checkOutput("busy5_req", 64'(irq_req_o), 64'd0);
    busy_i = 1'b0;
    waitCycles(1);
    checkOutput("busy_release_req", 64'(irq_req_o), 64'd1);

    $display("[TB] mret and masking ignored in REQ");
    pulseMret();
    checkOutput("req_mret_ignored", 64'(irq_req_o), 64'd1);
    applyStimulus(0, 0, 0, 32'h008, 0, 0);
    waitCycles(2);
    checkOutput("req_masked_held", 64'(irq_req_o), 64'd1);
    pulseAck();
    pulseMret();
    waitCycles(3);
    checkOutput("masked_idle", 64'(irq_req_o), 64'd0);

    $display("[TB] asynchronous reset during service");
    applyStimulus(0, 1, 0, 32'h008, 1, 0);
    waitCycles(1);
    pulseAck();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_req", 64'(irq_req_o), 64'd0);
    checkOutput("async_rst_cause", 64'(irq_cause_o), 64'd0);
`ifdef IRQ_SCHED_TIMER_EN
    checkOutput("async_rst_mtimecmp", mtimecmp_o, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
    #3 rst_n = 1'b1;
    #1;
    checkOutput("post_rst_no_early_req", 64'(irq_req_o), 64'd0);
    waitCycles(1);
    checkOutput("post_rst_first_req", 64'(irq_req_o), 64'd1);
    pulseAck();
    msip_i = 1'b0;
    pulseMret();
    waitCycles(2);

`ifdef IRQ_SCHED_TIMER_EN
    $display("[TB] timer compare interrupt");
    applyStimulus(0, 0, 0, 32'h080, 0, 0);
    tmrWrite(2'd1, 32'h0);
    tmrWrite(2'd0, 32'h0);
    tmrWrite(2'd3, 32'h0);
    tmrWrite(2'd2, 32'h10);
    global_int_en_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (irq_req_o) break;
      waitCycles(1);
    end
    checkOutput("tmr_req_seen", 64'(irq_req_o), 64'd1);
    checkOutput("tmr_cause", 64'(irq_cause_o), 64'h8000_0007);
    checkOutput("tmr_mtime_at_req", mtime_o, 64'h11);
    global_int_en_i = 1'b0;
    pulseAck();
    pulseMret();

    $display("[TB] mtime wrap and write priority");
    tmrWrite(2'd1, 32'hFFFF_FFFF);
    tmrWrite(2'd0, 32'hFFFF_FFFF);
    checkOutput("mtime_all_ones", mtime_o, 64'hFFFF_FFFF_FFFF_FFFF);
    waitCycles(1);
    checkOutput("mtime_wrap", mtime_o, 64'd0);
    tmrWrite(2'd0, 32'h5);
    checkOutput("mtime_write_wins", mtime_o, 64'h5);
`else
    $display("[TB] timer absent");
    tmrWrite(2'd0, 32'h1234);
    tmrWrite(2'd2, 32'h5678);
    checkOutput("no_tmr_mtime", mtime_o, 64'd0);
    checkOutput("no_tmr_mtimecmp", mtimecmp_o, 64'd0);
    applyStimulus(0, 0, 1, 32'h080, 1, 0);
    waitCycles(1);
    checkOutput("ext_mtip_cause", 64'(irq_cause_o), 64'h8000_0007);
    global_int_en_i = 1'b0;
    pulseAck();
    pulseMret();
`endif

    waitCycles(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
